ebi_master: RTL

//  Initiator side of the multiplexed 16-bit EBI address/data bus: turns single read/write

---
 rtl/ebi_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ebi_master.sv
// EBI bus initiator: single read/write requests become CS/ALE/strobe cycles on a multiplexed 16-bit AD bus.
// Optional `EBI_MASTER_WAIT_EN adds an ebi_ardy input that stretches the strobe (255-cycle timeout, reads return 16'hDEAD).
module ebi_master #(
  parameter int unsigned ADDR_SETUP   = 1,
  parameter int unsigned ALE_WIDTH    = 1,
  parameter int unsigned ADDR_HOLD    = 1,
  parameter int unsigned STROBE_WIDTH = 2,
  parameter int unsigned DATA_HOLD    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        ebi_cs,
  output logic        ebi_ale,
  output logic        ebi_we,
  output logic        ebi_re,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  input  logic [15:0] ad_in
`ifdef EBI_MASTER_WAIT_EN
  ,
  input  logic        ebi_ardy
`endif
);

  function automatic logic [3:0] clamp(input int unsigned v);
    if (v == 0) return 4'd1;
    if (v > 15) return 4'd15;
    return 4'(v);
  endfunction

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] LD_SETUP  = clamp(ADDR_SETUP)   - 4'd1;
  localparam logic [3:0] LD_ALE    = clamp(ALE_WIDTH)    - 4'd1;
  localparam logic [3:0] LD_AHOLD  = clamp(ADDR_HOLD)    - 4'd1;
  localparam logic [3:0] LD_STROBE = clamp(STROBE_WIDTH) - 4'd1;
  localparam logic [3:0] LD_DHOLD  = clamp(DATA_HOLD)    - 4'd1;

  typedef enum logic [2:0] {IDLE, ASETUP, ALE, AHOLD, STROBE, DHOLD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        wr_q;
  logic [15:0] addr_q, wdata_q;
  logic        capture;
  logic        strobe_end;
  logic        timed_out;

`ifdef EBI_MASTER_WAIT_EN
  logic [7:0] wait_cnt;

  assign strobe_end = ebi_ardy || (wait_cnt == 8'hFF);
  assign timed_out  = !ebi_ardy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == STROBE && cnt == '0 && !strobe_end) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else if (state != STROBE) begin
      wait_cnt <= '0;
    end
  end
`else
  assign strobe_end = 1'b1;
  assign timed_out  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= capture;
      if (state == IDLE && req_valid) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (capture) rsp_rdata <= timed_out ? 16'hDEAD : ad_in;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    req_ready = 1'b0;
    ebi_cs    = 1'b0;
    ebi_ale   = 1'b1;
    ebi_we    = 1'b1;
    ebi_re    = 1'b1;
    ad_out    = addr_q;
    ad_oe     = 1'b1;
    case (state)
      IDLE: begin
        ebi_cs    = 1'b1;
        ad_oe     = 1'b0;
        ad_out    = '0;
        // Gated by reset so ready stays low for as long as reset is held.
        req_ready = reset;
        if (req_valid) begin
          state_nxt = ASETUP;
          cnt_nxt   = LD_SETUP;
        end
      end
      ASETUP: begin
        if (cnt != '0) cnt_nxt = cnt - 4'd1;
        else begin
          state_nxt = ALE;
          cnt_nxt   = LD_ALE;
        end
      end
      ALE: begin
        ebi_ale = 1'b0;
        if (cnt != '0) cnt_nxt = cnt - 4'd1;
        else begin
          state_nxt = AHOLD;
          cnt_nxt   = LD_AHOLD;
        end
      end
      AHOLD: begin
        if (cnt != '0) cnt_nxt = cnt - 4'd1;
        else begin
          state_nxt = STROBE;
          cnt_nxt   = LD_STROBE;
        end
      end
      STROBE: begin
        if (wr_q) begin
          ebi_we = 1'b0;
          ad_out = wdata_q;
        end else begin
          ebi_re = 1'b0;
          ad_oe  = 1'b0;
        end
        if (cnt != '0) cnt_nxt = cnt - 4'd1;
        else if (strobe_end) begin
          state_nxt = DHOLD;
          cnt_nxt   = LD_DHOLD;
          capture   = !wr_q;
        end
      end
      DHOLD: begin
        if (wr_q) ad_out = wdata_q;
        else      ad_oe  = 1'b0;
        if (cnt != '0) cnt_nxt = cnt - 4'd1;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
